// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants, ALU encodings and ctrl word layout shared by all pipeline stages
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd3;
  localparam logic [5:0] OP_LW = 6'd4;
  localparam logic [5:0] OP_SW = 6'd5;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_MUL = 6'd50;
  localparam int CTRL_W = 12;
  localparam int DEST_LSB = 7;
  localparam int DEST_W = 5;
  localparam int REG_WRITE_BIT = 6;
  localparam int MEM_WRITE_BIT = 5;
  localparam int MEM_TO_REG_BIT = 4;
  localparam int ALU_SRC_BIT = 3;
  localparam int ALU_OP_LSB = 1;
  localparam int ALU_OP_W = 2;
  localparam int VALID_BIT = 0;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;
  typedef struct packed {
    logic [4:0] dest;
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    alu_op_t alu_op;
    logic valid;
  } ctrl_t;
endpackage

// File: rtl/control_if.sv
// control_if: fetch-to-decode instruction bus and decoded register addresses / control word
interface control_if;
  import cpu_pkg::*;
  logic [31:0] instr;
  logic [4:0] a_reg;
  logic [4:0] b_reg;
  logic [CTRL_W-1:0] ctrl;
  modport master(output instr, input a_reg, b_reg, ctrl);
  modport slave(input instr, output a_reg, b_reg, ctrl);
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational instruction decode into register addresses and control word
module control_decode
  import cpu_pkg::*;
(
  input logic [31:0] instr,
  output logic [4:0] a,
  output logic [4:0] b,
  output logic [CTRL_W-1:0] ctrl
);
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic r_ok;
  alu_op_t fn_op;
  ctrl_t c;
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];
  // Field extraction and per-opcode control word; unknown opcode or funct yields a bubble
  always_comb begin
    op = instr[31:26];
    funct = instr[5:0];
    rd = instr[15:11];
    a = instr[25:21];
    b = instr[20:16];
    r_ok = funct == FN_ADD || funct == FN_SUB || funct == FN_MUL || funct == FN_AND;
    fn_op = funct == FN_SUB ? ALU_SUB : funct == FN_MUL ? ALU_MUL : funct == FN_AND ? ALU_AND : ALU_ADD;
    c = op == OP_RTYPE && r_ok ? {rd, 1'b1, 1'b0, 1'b0, 1'b0, fn_op, 1'b1} :
        op == OP_LW ? {a, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b1} :
        op == OP_SW ? {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD, 1'b1} : '0;
    ctrl = c;
  end
endmodule

// File: rtl/control.sv
// control: registered instruction-decode stage producing read addresses and the pipeline control word
module control
  import cpu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  control_if.slave bus
);
  logic [4:0] a;
  logic [4:0] b;
  logic [CTRL_W-1:0] c;
  control_decode u_dec (
    .instr(bus.instr),
    .a(a),
    .b(b),
    .ctrl(c)
  );
  // Output register; reset forces a bubble immediately, discarding any in-flight decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.a_reg <= '0;
      bus.b_reg <= '0;
      bus.ctrl <= '0;
    end else begin
      bus.a_reg <= a;
      bus.b_reg <= b;
      bus.ctrl <= c;
    end
  end
endmodule

// File: tb/tb_control.sv
// tb_control: randomized and directed checks of the decode stage against an arithmetic reference model
module tb_control;
  logic clk = 0;
  logic rst_n = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [4:0] exp_a = '0;
  logic [4:0] exp_b = '0;
  logic [11:0] exp_c = '0;
  control_if bus();
  control dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // Reference decode from the instruction-set rules: ctrl built by weighted bit sums
  function automatic logic [21:0] ref_dec(logic [31:0] i);
    int op, ra, rb, rd, fn, k, c;
    op = int'(i[31:26]);
    ra = int'(i[25:21]);
    rb = int'(i[20:16]);
    rd = int'(i[15:11]);
    fn = int'(i[5:0]);
    c = 0;
    if (op == 3) begin
      k = fn == 32 ? 0 : fn == 34 ? 1 : fn == 50 ? 2 : fn == 36 ? 3 : -1;
      if (k >= 0) c = rd * 128 + 64 + k * 2 + 1;
    end else if (op == 4) c = ra * 128 + 64 + 16 + 8 + 1;
    else if (op == 5) c = 32 + 8 + 1;
    return {5'(ra), 5'(rb), 12'(c)};
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask
  // Model register: expectation is the decode of the instruction present at the last edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) {exp_a, exp_b, exp_c} <= '0;
    else {exp_a, exp_b, exp_c} <= ref_dec(bus.instr);
  end
  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if ($time > 0) begin
      chk("a_reg", 32'(bus.a_reg), 32'(exp_a));
      chk("b_reg", 32'(bus.b_reg), 32'(exp_b));
      chk("ctrl", 32'(bus.ctrl), 32'(exp_c));
    end
  end
  task automatic step(string name, logic [31:0] v, logic [4:0] ea, logic [4:0] eb, logic [11:0] ec);
    @(negedge clk);
    bus.instr = v;
    @(posedge clk);
    #1;
    chk({name, "_a"}, 32'(bus.a_reg), 32'(ea));
    chk({name, "_b"}, 32'(bus.b_reg), 32'(eb));
    chk({name, "_ctrl"}, 32'(bus.ctrl), 32'(ec));
    chk({name, "_model"}, 32'(exp_c), 32'(ec));
  endtask
  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    logic [5:0] fns [4];
    v = $urandom;
    fns = '{6'd32, 6'd34, 6'd36, 6'd50};
    case ($urandom_range(0, 3))
      0: v[31:26] = 6'd3;
      1: v[31:26] = 6'd4;
      2: v[31:26] = 6'd5;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) v[5:0] = fns[$urandom_range(0, 3)];
    return v;
  endfunction
  initial begin
    bus.instr = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 32'(bus.a_reg), 0);
    chk("reset_b", 32'(bus.b_reg), 0);
    chk("reset_ctrl", 32'(bus.ctrl), 0);
    @(negedge clk);
    rst_n = 1;
    step("lw", {6'd4, 5'd8, 5'd0, 16'h09F0}, 5'd8, 5'd0, 12'h459);
    step("sub", {6'd3, 5'd1, 5'd0, 5'd4, 5'd10, 6'd34}, 5'd1, 5'd0, 12'h243);
    step("mul", {6'd3, 5'd4, 5'd5, 5'd6, 5'd10, 6'd50}, 5'd4, 5'd5, 12'h345);
    step("sw", {6'd5, 5'd8, 5'd6, 16'h0DEF}, 5'd8, 5'd6, 12'h029);
    step("and_r0", {6'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'd36}, 5'd1, 5'd2, 12'h047);
    step("add", {6'd3, 5'd31, 5'd17, 5'd31, 5'd3, 6'd32}, 5'd31, 5'd17, 12'hFC1);
    step("bad_op", {6'd0, 5'd7, 5'd9, 16'h1234}, 5'd7, 5'd9, 12'h000);
    step("bad_fn", {6'd3, 5'd2, 5'd3, 5'd31, 5'd0, 6'd1}, 5'd2, 5'd3, 12'h000);
    step("lw_r31", {6'd4, 5'd31, 5'd30, 16'hFFFF}, 5'd31, 5'd30, 12'hFD9);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("async_a", 32'(bus.a_reg), 0);
    chk("async_b", 32'(bus.b_reg), 0);
    chk("async_ctrl", 32'(bus.ctrl), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.instr = rand_instr();
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_n = 0;
        #1;
        rst_n = 1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
